// File: rtl/uart_ctrl_pkg.sv
// ============================================================================
// uart_ctrl_pkg : shared FSM encoding, grant enum and default widths
// Revision      : 1.0
// ============================================================================
`default_nettype none

package uart_ctrl_pkg;

  localparam int DBIT_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Doubles as the round-robin pointer: holds the requester granted last.
  typedef enum logic {
    GNT_ECHO = 1'b0,
    GNT_SRC  = 1'b1
  } gnt_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter; req[0]/grant[0] = ECHO, [1] = SRC
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import uart_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_e       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie, the side that did not win last time goes first.
      2'b11:   grant = (pointer == GNT_SRC) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : merges rx echo traffic and a local producer into tx FIFO
// Revision        : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int DBIT  = DBIT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DBIT-1:0]  r_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [DBIT-1:0]  w_data,
  output logic             wr_uart,
  input  logic             src_valid,
  input  logic [DBIT-1:0]  src_data,
  output logic             src_ready,
  input  logic             echo_en,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  state_e           state_q, state_d;
  gnt_e             last_q, last_d;
  logic [DBIT-1:0]  w_data_q, w_data_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             src_rdy_q, src_rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req;
  logic [1:0]       grant;

  assign req = {src_valid, echo_en & ~rx_empty};

  rr_arb2 u_rr_arb2 (
    .req     (req),
    .pointer (last_q),
    .grant   (grant)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_q    <= GNT_SRC;
      w_data_q  <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      src_rdy_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      w_data_q  <= w_data_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      src_rdy_q <= src_rdy_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobes are computed one cycle early so they are flop outputs in SEND.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    w_data_d  = w_data_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    src_rdy_d = 1'b0;
    cnt_d     = wr_q ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!tx_full && (grant != 2'b00)) begin
          state_d = ST_SEND;
          wr_d    = 1'b1;
          if (grant[0]) begin
            rd_d     = 1'b1;
            w_data_d = r_data;
            last_d   = GNT_ECHO;
          end else begin
            src_rdy_d = 1'b1;
            w_data_d  = src_data;
            last_d    = GNT_SRC;
          end
        end
      end
      ST_SEND: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_uart    = rd_q;
  assign wr_uart    = wr_q;
  assign src_ready  = src_rdy_q;
  assign w_data     = w_data_q;
  assign byte_count = cnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : FIFO models, write scoreboard and directed scenarios
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int DBIT  = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [DBIT-1:0]  r_data = '0;
  logic             rx_empty = 1'b1;
  logic             rd_uart;
  logic             tx_full = 1'b0;
  logic [DBIT-1:0]  w_data;
  logic             wr_uart;
  logic             src_valid = 1'b0;
  logic [DBIT-1:0]  src_data = '0;
  logic             src_ready;
  logic             echo_en = 1'b0;
  logic [CNT_W-1:0] byte_count;
  logic             busy;

  typedef struct {
    logic [DBIT-1:0] data;
    bit              echo;
  } exp_t;

  exp_t            expq[$];
  logic [DBIT-1:0] rxq[$];
  logic [DBIT-1:0] srcq[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int prev_wr  = -1;
  bit gap_chk  = 1'b0;

  uart_tx_arbiter #(.DBIT(DBIT), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .r_data     (r_data),
    .rx_empty   (rx_empty),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .echo_en    (echo_en),
    .byte_count (byte_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [DBIT-1:0] d, input bit e);
    exp_t x;
    x.data = d;
    x.echo = e;
    expq.push_back(x);
  endtask

  // First-word-fall-through rx FIFO and producer models
  always @(negedge clock) begin
    logic [DBIT-1:0] tmp;
    if (rd_uart && rxq.size() > 0) tmp = rxq.pop_front();
    if (src_ready && srcq.size() > 0) tmp = srcq.pop_front();
    rx_empty  = (rxq.size() == 0);
    r_data    = rx_empty ? '0 : rxq[0];
    src_valid = (srcq.size() != 0);
    src_data  = src_valid ? srcq[0] : '0;
  end

  // Monitor: every tx push is matched against the scoreboard head
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      prev_wr = -1;
    end else if (wr_uart) begin
      if (expq.size() == 0) begin
        chk(1'b0, "unexpected_write", {24'd0, w_data}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk(w_data == e.data, "w_data", {24'd0, w_data}, {24'd0, e.data});
        chk({rd_uart, src_ready} == {e.echo, ~e.echo}, "pop_strobe",
            {30'd0, rd_uart, src_ready}, {30'd0, e.echo, ~e.echo});
      end
      if (gap_chk && prev_wr >= 0)
        chk((cyc - prev_wr) == 3, "write_spacing", cyc - prev_wr, 32'd3);
      prev_wr = cyc;
    end else if (rd_uart || src_ready) begin
      chk(1'b0, "stray_strobe", {30'd0, rd_uart, src_ready}, 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b0;
    tx_full = 1'b0;
    echo_en = 1'b0;
    rxq.delete();
    srcq.delete();
    expq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (expq.size() == 0 && !busy && !wr_uart) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ok, name, expq.size(), 32'd0);
  endtask

  initial begin
    bit seen;
    bit bad;

    // Asynchronous reset takes effect without a clock edge
    #2 reset = 1'b0;
    #1;
    chk({wr_uart, rd_uart, src_ready, busy} == 4'b0, "reset_strobes",
        {28'd0, wr_uart, rd_uart, src_ready, busy}, 32'd0);
    chk(w_data == '0, "reset_w_data", {24'd0, w_data}, 32'd0);
    chk(byte_count == '0, "reset_count", {28'd0, byte_count}, 32'd0);

    // Echo only
    do_reset();
    gap_chk = 1'b1;
    echo_en = 1'b1;
    rxq.push_back(8'h41); rxq.push_back(8'h42);
    push_exp(8'h41, 1'b1); push_exp(8'h42, 1'b1);
    drain("echo_drain");
    chk(byte_count == 4'd2, "echo_count", {28'd0, byte_count}, 32'd2);
    gap_chk = 1'b0;

    // Contention: ECHO wins the first tie after reset, then alternation
    do_reset();
    gap_chk = 1'b1;
    echo_en = 1'b1;
    rxq.push_back(8'h10); rxq.push_back(8'h11);
    srcq.push_back(8'hA0); srcq.push_back(8'hA1);
    push_exp(8'h10, 1'b1); push_exp(8'hA0, 1'b0);
    push_exp(8'h11, 1'b1); push_exp(8'hA1, 1'b0);
    drain("contention_drain");
    chk(byte_count == 4'd4, "contention_count", {28'd0, byte_count}, 32'd4);
    gap_chk = 1'b0;

    // Backpressure
    do_reset();
    tx_full = 1'b1;
    echo_en = 1'b1;
    rxq.push_back(8'h33);
    srcq.push_back(8'h77);
    push_exp(8'h33, 1'b1); push_exp(8'h77, 1'b0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (busy || wr_uart || rd_uart || src_ready) bad = 1'b1;
    end
    chk(!bad, "full_holds_idle", {31'd0, bad}, 32'd0);
    tx_full = 1'b0;
    @(negedge clock);
    chk(wr_uart && rd_uart, "first_write_latency", {30'd0, wr_uart, rd_uart}, 32'd3);
    drain("backpressure_drain");
    chk(byte_count == 4'd2, "backpressure_count", {28'd0, byte_count}, 32'd2);

    // Echo disabled: rx untouched, local bytes still flow
    do_reset();
    echo_en = 1'b0;
    rxq.push_back(8'h55);
    srcq.push_back(8'h5A); srcq.push_back(8'h5B);
    push_exp(8'h5A, 1'b0); push_exp(8'h5B, 1'b0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (rd_uart) bad = 1'b1;
    end
    chk(!bad, "no_rd_when_echo_off", {31'd0, bad}, 32'd0);
    chk(rxq.size() == 1 && r_data == 8'h55, "rx_preserved", {24'd0, r_data}, 32'h55);
    chk(byte_count == 4'd2, "echo_off_count", {28'd0, byte_count}, 32'd2);
    chk(expq.size() == 0, "echo_off_all_sent", expq.size(), 32'd0);

    // Reset in SEND, then tie goes back to ECHO
    do_reset();
    echo_en = 1'b1;
    rxq.push_back(8'h21);
    srcq.push_back(8'hC1);
    push_exp(8'h21, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (wr_uart) seen = 1'b1;
    end
    chk(seen, "midrst_send_seen", {31'd0, seen}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk({wr_uart, rd_uart, src_ready, busy} == 4'b0, "midrst_strobes",
        {28'd0, wr_uart, rd_uart, src_ready, busy}, 32'd0);
    chk(w_data == '0, "midrst_w_data", {24'd0, w_data}, 32'd0);
    chk(byte_count == '0, "midrst_count", {28'd0, byte_count}, 32'd0);
    rxq.push_back(8'h22);
    push_exp(8'h22, 1'b1); push_exp(8'hC1, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drain("midrst_drain");
    chk(byte_count == 4'd2, "midrst_final_count", {28'd0, byte_count}, 32'd2);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      srcq.push_back(8'(8'h80 + i));
      push_exp(8'(8'h80 + i), 1'b0);
    end
    drain("wrap_drain");
    chk(byte_count == 4'd1, "wrap_count", {28'd0, byte_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DBIT, default 8, UART data width in bits.
REQ-002 Parameter: CNT_W, default 16, byte-counter width.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: r_data  input  DBIT  rx FIFO head word; valid whenever rx_empty=0 (first-word-fall-through).
REQ-006 Port: rx_empty  input  1  rx FIFO empty flag, 1 = empty.
REQ-007 Port: rd_uart  output  1  rx FIFO pop strobe, one-cycle pulse.
REQ-008 Port: tx_full  input  1  tx FIFO full flag, 1 = full.
REQ-009 Port: w_data  output  DBIT  word written to tx FIFO.
REQ-010 Port: wr_uart  output  1  tx FIFO push strobe, one-cycle pulse.
REQ-011 Port: src_valid  input  1  local producer has a byte.
REQ-012 Port: src_data  input  DBIT  local producer byte; held stable while src_valid=1 until src_ready.
REQ-013 Port: src_ready  output  1  local producer byte consumed, one-cycle pulse.
REQ-014 Port: echo_en  input  1  1 = rx bytes are echoed to tx; 0 = rx FIFO left untouched.
REQ-015 Port: byte_count  output  CNT_W  number of tx FIFO pushes since reset.
REQ-016 Port: busy  output  1  1 whenever FSM is not IDLE.

Function
REQ-017 Requesters: ECHO request = echo_en & ~rx_empty; SRC request = src_valid.
REQ-018 FSM states IDLE, SEND, GAP; transitions IDLE->SEND on grant, SEND->GAP unconditionally, GAP->IDLE unconditionally.
REQ-019 Grant is evaluated only in IDLE and only when tx_full=0; tx_full=1 holds the FSM in IDLE with no strobes.
REQ-020 Single requester: it is granted. Both requesting: round-robin; the requester not granted last wins.
REQ-021 On grant in cycle N, the granted byte (r_data or src_data) is captured into w_data at the end of cycle N.
REQ-022 In cycle N+1 (SEND), wr_uart=1 and exactly one of rd_uart (ECHO) or src_ready (SRC) equals 1; all strobes are registered outputs.
REQ-023 In GAP, all strobes are 0, so FIFO flags settle; maximum throughput is one byte per 3 cycles.
REQ-024 Once in SEND, the write completes regardless of tx_full, echo_en or src_valid changes.
REQ-025 w_data holds its last value outside SEND.
REQ-026 byte_count increments by 1 on every wr_uart pulse; wraps from 2^CNT_W-1 to 0 with no flag.
REQ-027 echo_en=0 with rx_empty=0: rd_uart never asserts; rx data is preserved.
REQ-028 No request in IDLE: FSM stays IDLE and all strobes remain 0.

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, rd_uart=0, wr_uart=0, src_ready=0, w_data=0, byte_count=0, busy=0.
REQ-030 Round-robin pointer resets to "last granted = SRC", so ECHO wins the first tie.
REQ-031 Reset asserted in SEND or GAP aborts the transfer; no strobe is emitted after reset release until a new grant.

Structure
REQ-032 Shared package uart_ctrl_pkg holds the FSM state encoding, grant enum (GNT_ECHO, GNT_SRC), and default DBIT/CNT_W constants.
REQ-033 The two-way round-robin decision is one sub-module, rr_arb2 (req[1:0], pointer, grant[1:0]); the rest is flat.

Verification
REQ-034 Echo only: echo_en=1, rx FIFO loaded with 0x41, 0x42 -> wr_uart pulses with w_data 0x41 then 0x42, 3 cycles apart; rd_uart coincides with each; byte_count=2.
REQ-035 Contention: echo_en=1, rx holds 0x10, 0x11; src_valid=1 with 0xA0, then 0xA1 -> tx order 0x10, 0xA0, 0x11, 0xA1.
REQ-036 Backpressure: tx_full=1 with both requesting for 10 cycles -> no strobes and busy=0; tx_full=0 -> first wr_uart 1 cycle after the grant cycle.
REQ-037 echo_en=0 with rx holding 0x55 -> rd_uart never asserts over 20 cycles; src bytes still pass.
REQ-038 Mid-operation reset: reset=0 during SEND -> all outputs 0 immediately; after release with requests present, the next tie grants ECHO.
REQ-039 Wrap: CNT_W=4, 17 transfers -> byte_count reads 1.
